// File: rtl/cnn_ofm_writer.sv
// cnn_ofm_writer
//   Output-side collector for the cnn compute engine. Partial-sum beats arrive
//   in the fixed order mt (outer), nt, r, c (inner). The beats of the first and
//   middle input-channel tiles are summed into a local accumulator. The beat of
//   the last input tile completes the sum, which is saturated to DATA_W_p and
//   written out through a registered output stage. done_o pulses once after
//   the final write handshake of the layer.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i                 begin a layer; only looked at in IDLE
//   busy_o, done_o          layer in progress / one-cycle completion pulse
//   psum_v_i, psum_ready_o  beat handshake from the engine
//   psum_i                  Tm_p signed lanes, lane j at [j*DATA_W_p +: DATA_W_p]
//   wr_v_o, wr_ready_i      output buffer write handshake
//   wr_addr_o               mt*R_p*C_p + r*C_p + c
//   wr_data_o               saturated lanes, same packing as psum_i
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting beats and issuing writes
// FLUSH | last beat taken; waiting for the final write handshake
module cnn_ofm_writer #(
    parameter int N_p      = 4,
    parameter int M_p      = 4,
    parameter int R_p      = 16,
    parameter int C_p      = 16,
    parameter int Tn_p     = 2,
    parameter int Tm_p     = 2,
    parameter int DATA_W_p = 16,
    parameter int ACC_W_p  = 24
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     start_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    input  logic                                     psum_v_i,
    output logic                                     psum_ready_o,
    input  logic [Tm_p*DATA_W_p-1:0]                 psum_i,
    output logic                                     wr_v_o,
    input  logic                                     wr_ready_i,
    output logic [$clog2(M_p*R_p*C_p/Tm_p)-1:0]      wr_addr_o,
    output logic [Tm_p*DATA_W_p-1:0]                 wr_data_o
);

    localparam int NT     = N_p / Tn_p;
    localparam int MT     = M_p / Tm_p;
    localparam int RC     = R_p * C_p;
    localparam int ADDR_W = $clog2(M_p*R_p*C_p/Tm_p);
    localparam int C_W    = (C_p > 1) ? $clog2(C_p) : 1;
    localparam int R_W    = (R_p > 1) ? $clog2(R_p) : 1;
    localparam int NT_W   = (NT > 1) ? $clog2(NT) : 1;
    localparam int MT_W   = (MT > 1) ? $clog2(MT) : 1;
    localparam int IDX_W  = (RC > 1) ? $clog2(RC) : 1;

    localparam logic signed [ACC_W_p-1:0] SAT_MAX =
        {{(ACC_W_p-DATA_W_p+1){1'b0}}, {(DATA_W_p-1){1'b1}}};
    localparam logic signed [ACC_W_p-1:0] SAT_MIN =
        {{(ACC_W_p-DATA_W_p+1){1'b1}}, {(DATA_W_p-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state_q, state_d;

    logic [C_W-1:0]  c_q;
    logic [R_W-1:0]  r_q;
    logic [NT_W-1:0] nt_q;
    logic [MT_W-1:0] mt_q;

    logic                       wr_v_q;
    logic                       done_q;
    logic [ADDR_W-1:0]          wr_addr_q;
    logic [Tm_p*DATA_W_p-1:0]   wr_data_q;

    logic signed [ACC_W_p-1:0]  acc_q [RC][Tm_p];

    logic signed [DATA_W_p-1:0] lane_w [Tm_p];
    logic signed [ACC_W_p-1:0]  sum_w  [Tm_p];
    logic [Tm_p*DATA_W_p-1:0]   sat_data;

    logic              psum_ready;
    logic              accept;
    logic              c_last, r_last, nt_first, nt_last, mt_last, last_beat;
    logic              wr_hs;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr_w;

    assign c_last    = (c_q  == C_W'(C_p - 1));
    assign r_last    = (r_q  == R_W'(R_p - 1));
    assign nt_first  = (nt_q == '0);
    assign nt_last   = (nt_q == NT_W'(NT - 1));
    assign mt_last   = (mt_q == MT_W'(MT - 1));
    assign last_beat = c_last && r_last && nt_last && mt_last;
    assign accept    = psum_v_i && psum_ready;
    assign wr_hs     = wr_v_q && wr_ready_i;

    assign idx    = IDX_W'(int'(r_q) * C_p + int'(c_q));
    assign addr_w = ADDR_W'(int'(mt_q) * RC + int'(r_q) * C_p + int'(c_q));

    // The first tile overwrites, so the accumulator never needs clearing.
    always_comb begin
        sat_data = '0;
        for (int j = 0; j < Tm_p; j++) begin
            lane_w[j] = psum_i[j*DATA_W_p +: DATA_W_p];
            sum_w[j]  = nt_first ? ACC_W_p'(lane_w[j])
                                 : acc_q[idx][j] + ACC_W_p'(lane_w[j]);
            if (sum_w[j] > SAT_MAX) begin
                sat_data[j*DATA_W_p +: DATA_W_p] = SAT_MAX[DATA_W_p-1:0];
            end else if (sum_w[j] < SAT_MIN) begin
                sat_data[j*DATA_W_p +: DATA_W_p] = SAT_MIN[DATA_W_p-1:0];
            end else begin
                sat_data[j*DATA_W_p +: DATA_W_p] = sum_w[j][DATA_W_p-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        psum_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                // A beat may only be taken if the output register is free or
                // being drained this cycle.
                psum_ready = !wr_v_q || wr_ready_i;
                if (psum_v_i && psum_ready && last_beat) state_d = FLUSH;
            end
            FLUSH: begin
                if (wr_v_q && wr_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            c_q     <= '0;
            r_q     <= '0;
            nt_q    <= '0;
            mt_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FLUSH) && wr_hs;
            if (state_q == IDLE && start_i) begin
                c_q  <= '0;
                r_q  <= '0;
                nt_q <= '0;
                mt_q <= '0;
            end else if (accept) begin
                if (c_last) begin
                    c_q <= '0;
                    if (r_last) begin
                        r_q <= '0;
                        if (nt_last) begin
                            nt_q <= '0;
                            mt_q <= mt_last ? '0 : mt_q + 1'b1;
                        end else begin
                            nt_q <= nt_q + 1'b1;
                        end
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_v_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (accept && nt_last) begin
            wr_v_q    <= 1'b1;
            wr_addr_q <= addr_w;
            wr_data_q <= sat_data;
        end else if (wr_hs) begin
            wr_v_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && accept && !nt_last) begin
            for (int j = 0; j < Tm_p; j++) begin
                acc_q[idx][j] <= sum_w[j];
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign psum_ready_o = psum_ready;
    assign wr_v_o       = wr_v_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_cnn_ofm_writer.sv
module tb_cnn_ofm_writer;

    localparam int NB     = 1024;
    localparam int NW     = 512;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i, busy_o, done_o, psum_v_i, psum_ready_o;
    logic [31:0] psum_i;
    logic        wr_v_o, wr_ready_i;
    logic [8:0]  wr_addr_o;
    logic [31:0] wr_data_o;

    logic        s2_start, s2_busy, s2_done, s2_v, s2_ready, s2_wr_v, s2_wr_ready;
    logic [31:0] s2_psum, s2_data;
    logic [3:0]  s2_addr;

    always #5 clk = ~clk;

    cnn_ofm_writer u_dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .psum_v_i(psum_v_i), .psum_ready_o(psum_ready_o),
        .psum_i(psum_i), .wr_v_o(wr_v_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    cnn_ofm_writer #(
        .N_p(2), .M_p(4), .R_p(2), .C_p(3), .Tn_p(2), .Tm_p(2),
        .DATA_W_p(16), .ACC_W_p(24)
    ) u_dut2 (
        .clk_i(clk), .reset_i(reset_i), .start_i(s2_start), .busy_o(s2_busy),
        .done_o(s2_done), .psum_v_i(s2_v), .psum_ready_o(s2_ready),
        .psum_i(s2_psum), .wr_v_o(s2_wr_v), .wr_ready_i(s2_wr_ready),
        .wr_addr_o(s2_addr), .wr_data_o(s2_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] beat_data [NB];
    logic [31:0] got_mem   [NW];
    wr_t         exp_q[$];

    function automatic logic [15:0] sat16(input int s);
        logic signed [23:0] w;
        w = s[23:0];
        if (w > 24'sd32767)  return 16'h7fff;
        if (w < -24'sd32768) return 16'h8000;
        return w[15:0];
    endfunction

    // Beat index of (mt, nt, r, c) in the engine's stream order.
    function automatic int beat_idx(input int mt, input int nt, input int r, input int c);
        return ((mt * 2 + nt) * 16 + r) * 16 + c;
    endfunction

    task automatic build_expected();
        wr_t e;
        int  s;
        exp_q.delete();
        for (int mt = 0; mt < 2; mt++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    e.addr = mt * 256 + r * 16 + c;
                    e.data = '0;
                    for (int j = 0; j < 2; j++) begin
                        s = 0;
                        for (int nt = 0; nt < 2; nt++)
                            s += int'($signed(beat_data[beat_idx(mt, nt, r, c)][j*16 +: 16]));
                        e.data[j*16 +: 16] = sat16(s);
                    end
                    exp_q.push_back(e);
                end
    endtask

    task automatic fill_const(input logic [15:0] l0, input logic [15:0] l1);
        for (int i = 0; i < NB; i++) beat_data[i] = {l1, l0};
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) beat_data[i] = $urandom;
    endtask

    // ---------------- compare process ----------------
    int          cyc = 0;
    int          wr_count = 0;
    int          done_count = 0;
    int          last_hs_cyc = -10;
    bit          hold_pending = 1'b0;
    logic [8:0]  hold_addr;
    logic [31:0] hold_data;
    wr_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_i) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", 64'(wr_v_o), 64'(1));
                chk("hold_addr", 64'(wr_addr_o), 64'(hold_addr));
                chk("hold_data", 64'(wr_data_o), 64'(hold_data));
            end
            hold_pending = wr_v_o && !wr_ready_i;
            hold_addr    = wr_addr_o;
            hold_data    = wr_data_o;
            if (wr_v_o && !wr_ready_i) chk("stall_ready", 64'(psum_ready_o), 64'(0));
            if (!busy_o) chk("idle_ready", 64'(psum_ready_o), 64'(0));
            if (wr_v_o && wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%h required=none", wr_addr_o, wr_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr_o), 64'(mon_e.addr));
                    chk("wr_data", 64'(wr_data_o), 64'(mon_e.data));
                end
                got_mem[wr_addr_o] = wr_data_o;
                wr_count++;
                last_hs_cyc = cyc;
            end
            if (done_o) begin
                done_count++;
                chk("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic ready_val(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return $urandom_range(1) == 1;
        endcase
    endfunction

    task automatic run_layer(input int rmode, input int bubble_pct, input int abort_after);
        int idx, cycles, d0;
        bit aborted;
        idx = 0; cycles = 0; aborted = 1'b0; d0 = done_count; wr_count = 0;
        for (int a = 0; a < NW; a++) got_mem[a] = '0;
        @(posedge clk); #1;
        start_i = 1'b1; wr_ready_i = 1'b1; psum_v_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(1));
        while (idx < NB && cycles < BUDGET) begin
            wr_ready_i = ready_val(rmode);
            psum_v_i   = ($urandom_range(99) >= bubble_pct);
            psum_i     = beat_data[idx];
            start_i    = (cycles == 50);
            @(negedge clk);
            if (psum_v_i && psum_ready_o) idx++;
            @(posedge clk); #1;
            cycles++;
            if (abort_after > 0 && idx == abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        psum_v_i = 1'b0;
        start_i  = 1'b0;
        if (aborted) begin
            reset_i = 1'b1;
            @(posedge clk); #1;
            reset_i = 1'b0;
            chk("abort_busy", 64'(busy_o), 64'(0));
            chk("abort_wr_v", 64'(wr_v_o), 64'(0));
            chk("abort_ready", 64'(psum_ready_o), 64'(0));
            chk("abort_done", 64'(done_o), 64'(0));
            exp_q.delete();
            return;
        end
        if (idx < NB) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout accepted=%0d required=%0d", idx, NB);
        end
        while (done_count == d0 && cycles < BUDGET) begin
            wr_ready_i = ready_val(rmode);
            @(posedge clk); #1;
            cycles++;
        end
        wr_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 64'(done_count - d0), 64'(1));
        chk("write_count", 64'(wr_count), 64'(NW));
        chk("exp_empty", 64'(exp_q.size()), 64'(0));
        chk("idle_busy", 64'(busy_o), 64'(0));
    endtask

    // Single-tile instance: every beat is its own output word.
    task automatic run_small();
        logic [31:0] bd2 [12];
        logic [31:0] first_data;
        int k, n, cycles, dcnt;
        for (int i = 0; i < 12; i++) bd2[i] = (i == 0) ? {16'd100, 16'd100} : $urandom;
        k = 0; n = 0; cycles = 0; dcnt = 0; first_data = '0;
        @(posedge clk); #1;
        s2_start = 1'b1; s2_wr_ready = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0;
        while ((k < 12 || n < 12) && cycles < 200) begin
            s2_v        = (k < 12);
            s2_psum     = (k < 12) ? bd2[k] : '0;
            s2_start    = (k == 5);
            s2_wr_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (s2_wr_v && s2_wr_ready) begin
                if (n < 12) begin
                    chk("s2_addr", 64'(s2_addr), 64'(n));
                    chk("s2_data", 64'(s2_data), 64'(bd2[n]));
                    if (n == 0) first_data = s2_data;
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL s2_extra_write addr=%0d required=none", s2_addr);
                end
                n++;
            end
            if (s2_v && s2_ready) k++;
            @(posedge clk); #1;
            cycles++;
        end
        s2_v = 1'b0; s2_start = 1'b0; s2_wr_ready = 1'b1;
        chk("s2_writes", 64'(n), 64'(12));
        chk("s2_first_word", 64'(first_data), 64'h0064_0064);
        repeat (4) begin
            @(negedge clk);
            if (s2_done) dcnt++;
        end
        chk("s2_done_once", 64'(dcnt), 64'(1));
        chk("s2_idle", 64'(s2_busy), 64'(0));
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; psum_v_i = 1'b0; psum_i = '0; wr_ready_i = 1'b0;
        s2_start = 1'b0; s2_v = 1'b0; s2_psum = '0; s2_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_wr_v", 64'(wr_v_o), 64'(0));
        chk("rst_addr", 64'(wr_addr_o), 64'(0));
        chk("rst_data", 64'(wr_data_o), 64'(0));
        chk("rst_ready", 64'(psum_ready_o), 64'(0));
        chk("rst_s2_busy", 64'(s2_busy), 64'(0));
        reset_i = 1'b0;

        // all lanes 1, always ready
        fill_const(16'd1, 16'd1);
        build_expected();
        run_layer(0, 0, 0);
        chk("ones_word0", 64'(got_mem[0]), 64'h0002_0002);
        chk("ones_word511", 64'(got_mem[511]), 64'h0002_0002);

        // saturation both ways
        fill_const(16'd30000, 16'(-30000));
        build_expected();
        run_layer(0, 10, 0);
        chk("sat_word7", 64'(got_mem[7]), 64'h8000_7fff);

        // ready 1 of 3 cycles
        fill_const(16'd1, 16'd1);
        build_expected();
        run_layer(1, 0, 0);
        chk("slow_word300", 64'(got_mem[300]), 64'h0002_0002);

        // random data, random ready and bubbles, one pinned point
        fill_random();
        beat_data[beat_idx(1, 0, 2, 3)][15:0] = 16'd5;
        beat_data[beat_idx(1, 1, 2, 3)][15:0] = 16'hfff9;
        build_expected();
        run_layer(2, 20, 0);
        chk("pin_addr291_lane0", 64'(got_mem[291][15:0]), 64'hfffe);

        // abort after 300 beats, then full rerun with lanes = 3
        fill_const(16'd2, 16'd2);
        build_expected();
        run_layer(0, 0, 300);
        fill_const(16'd3, 16'd3);
        build_expected();
        run_layer(0, 0, 0);
        chk("rerun_word0", 64'(got_mem[0]), 64'h0006_0006);
        chk("rerun_word511", 64'(got_mem[511]), 64'h0006_0006);

        run_small();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
